// File: rtl/hmmm_muldiv_pkg.sv
// Shared HMMM core types: instruction word, ALU ops and the multi-cycle mul/div unit's op and state encodings.
package hmmm_pkg;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } instr_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SHL    = 4'd5,
        ALU_SHR    = 4'd6,
        ALU_MULDIV = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIV  = 2'd1,
        MD_MOD  = 2'd2,
        MD_RSVD = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/hmmm_muldiv_if.sv
// Request/response handshake bundle between the HMMM core (master) and the mul/div unit (slave).
interface hmmm_muldiv_if
    import hmmm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) ();
    logic             req_valid;
    logic             req_ready;
    muldiv_op_t       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_dbz;
    logic             resp_ovf;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_dbz, resp_ovf, resp_tag, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_dbz, resp_ovf, resp_tag, busy
    );
endinterface

// File: rtl/hmmm_muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, subtract if it fits.
module hmmm_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] trial_s;

    // Trial subtraction; the difference always fits WIDTH bits because rem < divisor
    always_comb begin
        trial_s = {rem, next_bit};
        q_bit   = (trial_s >= {1'b0, divisor});
        if (q_bit) begin
            rem_next = trial_s[WIDTH-1:0] - divisor;
        end else begin
            rem_next = trial_s[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/hmmm_muldiv.sv
// Multi-cycle signed MUL/DIV/MOD unit, one bit per cycle, with tag passthrough.
// Define HMMM_MULDIV_FAST_MUL_EN for a single-cycle multiply at accept.
module hmmm_muldiv
    import hmmm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    hmmm_muldiv_if.slave md
);
    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    muldiv_op_t         op_r;
    logic [TAG_W-1:0]   tag_r;
    logic [WIDTH-1:0]   a_mag_r, b_mag_r, rem_r, quo_r;
    logic [2*WIDTH-1:0] prod_r;
    logic               neg_res_r, neg_rem_r, div_ovf_r, dbz_r, short_r;
    logic               resp_valid_r, resp_dbz_r, resp_ovf_r;
    logic [WIDTH-1:0]   resp_result_r;
    logic [TAG_W-1:0]   resp_tag_r;

    logic               accept_s, dbz_s, short_s, q_bit_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, rem_step_s, quo_step_s, quo_sgn_s, rem_sgn_s, a_back_s;
    logic [2*WIDTH-1:0] prod_step_s, prod_fin_s, mul_sgn_s;
    logic [WIDTH-1:0]   fin_result_s;
    logic               fin_dbz_s, fin_ovf_s;

    assign accept_s       = md.req_valid && (state_r == IDLE);
    assign md.req_ready   = (state_r == IDLE);
    assign md.busy        = (state_r != IDLE);
    assign md.resp_valid  = resp_valid_r;
    assign md.resp_result = resp_result_r;
    assign md.resp_dbz    = resp_dbz_r;
    assign md.resp_ovf    = resp_ovf_r;
    assign md.resp_tag    = resp_tag_r;

    hmmm_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_r),
        .divisor  (b_mag_r),
        .next_bit (a_mag_r[cnt_r]),
        .rem_next (rem_step_s),
        .q_bit    (q_bit_s)
    );

    // Request decode: operand magnitudes and whether the op finishes after a single cycle
    always_comb begin
        a_mag_s = md.req_a[WIDTH-1] ? (-md.req_a) : md.req_a;
        b_mag_s = md.req_b[WIDTH-1] ? (-md.req_b) : md.req_b;
        dbz_s   = (md.req_b == {WIDTH{1'b0}}) && ((md.req_op == MD_DIV) || (md.req_op == MD_MOD));
`ifdef HMMM_MULDIV_FAST_MUL_EN
        short_s = dbz_s || (md.req_op == MD_RSVD) || (md.req_op == MD_MUL);
`else
        short_s = dbz_s || (md.req_op == MD_RSVD);
`endif
    end

    // Iteration step and sign-corrected final result/flags, valid on the last BUSY cycle
    always_comb begin
        prod_step_s = (prod_r << 1) + (b_mag_r[cnt_r] ? {{WIDTH{1'b0}}, a_mag_r} : {(2*WIDTH){1'b0}});
        quo_step_s  = (quo_r << 1) | {{(WIDTH-1){1'b0}}, q_bit_s};
        prod_fin_s  = short_r ? prod_r : prod_step_s;
        mul_sgn_s   = neg_res_r ? (-prod_fin_s) : prod_fin_s;
        quo_sgn_s   = neg_res_r ? (-quo_step_s) : quo_step_s;
        rem_sgn_s   = neg_rem_r ? (-rem_step_s) : rem_step_s;
        a_back_s    = neg_rem_r ? (-a_mag_r) : a_mag_r;
        fin_result_s = {WIDTH{1'b0}};
        fin_dbz_s    = 1'b0;
        fin_ovf_s    = 1'b0;
        case (op_r)
            MD_MUL: begin
                fin_result_s = mul_sgn_s[WIDTH-1:0];
                fin_ovf_s    = !((&mul_sgn_s[2*WIDTH-1:WIDTH-1]) || !(|mul_sgn_s[2*WIDTH-1:WIDTH-1]));
            end
            MD_DIV: begin
                fin_dbz_s    = dbz_r;
                fin_result_s = dbz_r ? {WIDTH{1'b1}} : quo_sgn_s;
                fin_ovf_s    = div_ovf_r;
            end
            MD_MOD: begin
                fin_dbz_s    = dbz_r;
                fin_result_s = dbz_r ? a_back_s : rem_sgn_s;
            end
            default: begin
                fin_result_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; single-cycle ops still pass through one BUSY cycle so DONE lands at accept+1
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = accept_s ? BUSY : IDLE;
            BUSY:    state_next_s = (cnt_r == {CNT_W{1'b0}}) ? DONE : BUSY;
            DONE:    state_next_s = md.resp_ready ? IDLE : DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, iteration registers and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};  op_r <= MD_MUL;  tag_r <= {TAG_W{1'b0}};
            a_mag_r <= {WIDTH{1'b0}};  b_mag_r <= {WIDTH{1'b0}};
            rem_r <= {WIDTH{1'b0}};  quo_r <= {WIDTH{1'b0}};  prod_r <= {(2*WIDTH){1'b0}};
            neg_res_r <= 1'b0;  neg_rem_r <= 1'b0;  div_ovf_r <= 1'b0;  dbz_r <= 1'b0;  short_r <= 1'b0;
            resp_valid_r <= 1'b0;  resp_result_r <= {WIDTH{1'b0}};
            resp_dbz_r <= 1'b0;  resp_ovf_r <= 1'b0;  resp_tag_r <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r      <= md.req_op;
                        tag_r     <= md.req_tag;
                        a_mag_r   <= a_mag_s;
                        b_mag_r   <= b_mag_s;
                        neg_res_r <= md.req_a[WIDTH-1] ^ md.req_b[WIDTH-1];
                        neg_rem_r <= md.req_a[WIDTH-1];
                        div_ovf_r <= (md.req_op == MD_DIV) && (md.req_b == {WIDTH{1'b1}})
                                     && (md.req_a == {1'b1, {(WIDTH-1){1'b0}}});
                        dbz_r     <= dbz_s;
                        short_r   <= short_s;
                        cnt_r     <= short_s ? {CNT_W{1'b0}} : CNT_W'(WIDTH-1);
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= {WIDTH{1'b0}};
`ifdef HMMM_MULDIV_FAST_MUL_EN
                        prod_r    <= {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
`else
                        prod_r    <= {(2*WIDTH){1'b0}};
`endif
                    end
                end
                BUSY: begin
                    prod_r <= prod_step_s;
                    rem_r  <= rem_step_s;
                    quo_r  <= quo_step_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        resp_valid_r  <= 1'b1;
                        resp_result_r <= fin_result_s;
                        resp_dbz_r    <= fin_dbz_s;
                        resp_ovf_r    <= fin_ovf_s;
                        resp_tag_r    <= tag_r;
                    end
                end
                DONE: begin
                    if (md.resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hmmm_muldiv.sv
// Self-checking bench for hmmm_muldiv: directed spec cases plus random ops against an arithmetic reference model.
module tb_hmmm_muldiv;
    import hmmm_pkg::*;

    localparam int W  = 16;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hmmm_muldiv_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    hmmm_muldiv #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .md(bus));

    int tests = 0;
    int fails = 0;
    logic [W-1:0]  last_result;
    bit            p_en = 1'b0;
    logic [1:0]    p_op;
    logic [W-1:0]  p_a, p_b;
    logic [TW-1:0] p_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic d, output logic o, output int lat);
        longint sa, sb, p;
        longint maxv, minv;
        maxv = (longint'(1) <<< (W-1)) - 1;
        minv = -(longint'(1) <<< (W-1));
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; d = 1'b0; o = 1'b0; lat = W;
        case (op)
            2'd0: begin
                p = sa * sb;
                r = p[W-1:0];
                o = (p > maxv) || (p < minv);
`ifdef HMMM_MULDIV_FAST_MUL_EN
                lat = 1;
`endif
            end
            2'd1: begin
                if (sb == 0) begin
                    r = '1; d = 1'b1; lat = 1;
                end else if (sa == minv && sb == -1) begin
                    r = a; o = 1'b1;
                end else begin
                    p = sa / sb; r = p[W-1:0];
                end
            end
            2'd2: begin
                if (sb == 0) begin
                    r = a; d = 1'b1; lat = 1;
                end else begin
                    p = sa % sb; r = p[W-1:0];
                end
            end
            default: lat = 1;
        endcase
    endfunction

    // Issue one request from IDLE, check latency, response and backpressure, then complete the handshake
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input int hold);
        logic [W-1:0] er;
        logic ed, eo;
        int lat, edges;
        model(op, a, b, er, ed, eo, lat);
        bus.req_valid = 1'b1; bus.req_op = muldiv_op_t'(op);
        bus.req_a = a; bus.req_b = b; bus.req_tag = tag; bus.resp_ready = 1'b0;
        chk("req_ready_idle", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("busy_after_accept", {bus.busy, bus.req_ready, bus.resp_valid}, 3'b100);
        edges = 0;
        while (bus.resp_valid !== 1'b1 && edges < 4*W) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, lat);
        chk("result", bus.resp_result, er);
        chk("flags", {bus.resp_dbz, bus.resp_ovf}, {ed, eo});
        chk("tag", bus.resp_tag, tag);
        last_result = bus.resp_result;
        if (p_en) begin
            bus.req_valid = 1'b1; bus.req_op = muldiv_op_t'(p_op);
            bus.req_a = p_a; bus.req_b = p_b; bus.req_tag = p_tag;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", {bus.resp_valid, bus.req_ready, bus.resp_result, bus.resp_tag},
                {1'b1, 1'b0, er, tag});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("idle_after_hs", {bus.resp_valid, bus.req_ready, bus.busy}, 3'b010);
    endtask

    initial begin
        bit seen;
        logic [1:0] op;
        logic [W-1:0] a, b;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = MD_MUL; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_state", {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_result,
                            bus.resp_dbz, bus.resp_ovf, bus.resp_tag}, {3'b100, 16'h0, 2'b00, 4'h0});

        run_op(2'd0, 16'd7, 16'hFFFD, 4'h1, 0);   chk("mul_7_m3", last_result, 16'hFFEB);
        run_op(2'd1, 16'hFFF9, 16'd2, 4'h2, 0);   chk("div_m7_2", last_result, 16'hFFFD);
        run_op(2'd2, 16'hFFF9, 16'd2, 4'h3, 0);   chk("mod_m7_2", last_result, 16'hFFFF);
        run_op(2'd2, 16'd7, 16'hFFFE, 4'h4, 0);   chk("mod_7_m2", last_result, 16'h0001);
        run_op(2'd1, 16'd5, 16'd0, 4'h5, 0);      chk("div_by_0", last_result, 16'hFFFF);
        run_op(2'd2, 16'd5, 16'd0, 4'h6, 0);      chk("mod_by_0", last_result, 16'h0005);
        run_op(2'd0, 16'd300, 16'd300, 4'h7, 0);  chk("mul_ovf", last_result, 16'h5F90);
        run_op(2'd1, 16'h8000, 16'hFFFF, 4'h8, 1); chk("div_min_m1", last_result, 16'h8000);
        run_op(2'd2, 16'h8000, 16'hFFFF, 4'h9, 0); chk("mod_min_m1", last_result, 16'h0000);
        run_op(2'd3, 16'h1234, 16'h5678, 4'hB, 0); chk("rsvd_op", last_result, 16'h0000);

        // Backpressure with a request waiting behind the held response
        p_en = 1'b1; p_op = 2'd0; p_a = 16'h0123; p_b = 16'h0045; p_tag = 4'h5;
        run_op(2'd1, 16'd100, 16'd7, 4'h6, 5);
        p_en = 1'b0;
        run_op(p_op, p_a, p_b, p_tag, 0);

        // Reset in the eighth BUSY cycle discards the operation
        bus.req_valid = 1'b1; bus.req_op = MD_DIV; bus.req_a = 16'd1000; bus.req_b = 16'd3; bus.req_tag = 4'hC;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 chk("busy_before_rst", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_abort", {bus.resp_valid, bus.req_ready, bus.busy, bus.resp_result,
                          bus.resp_dbz, bus.resp_ovf, bus.resp_tag}, {3'b010, 16'h0, 2'b00, 4'h0});
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) seen = 1'b1;
        end
        chk("no_resp_after_rst", seen, 0);
        run_op(2'd0, 16'h0011, 16'h0022, 4'hA, 0); chk("tag_a", bus.resp_tag, 4'hA);

        for (int n = 0; n < 80; n++) begin
            op = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'h0000;
            if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            run_op(op, a, b, 4'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
